// File: rtl/zinde_pkg.sv
// -----------------------------------------------------------------------------
// zinde_pkg
// Shared definitions for the ZindeRV8 serial boot loader: loader and UART
// receiver state encodings, the frame header byte and the default bit period.
// -----------------------------------------------------------------------------
package zinde_pkg;

   // Loader FSM states
   typedef enum logic [2:0] {
      LD_IDLE = 3'd0,
      LD_LEN  = 3'd1,
      LD_DATA = 3'd2,
      LD_SUM  = 3'd3,
      LD_RUN  = 3'd4,
      LD_ERR  = 3'd5
   } ld_state_t;

   // UART receiver states
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   localparam logic [7:0] LOAD_HEADER          = 8'hA5;
   localparam int         DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/zinde_uart_rx.sv
// -----------------------------------------------------------------------------
// zinde_uart_rx
// 8N1 UART receiver: 2-flop synchronizer, start-bit glitch rejection at the
// start mid-point, LSB-first data sampling at bit mid-points, stop-bit check.
// Ports:
//   clkn        in   system clock, rising edge
//   rstn        in   asynchronous active-low reset
//   rx          in   serial line, idle high, asynchronous
//   byte_valid  out  1-cycle pulse, the cycle after a good stop sample
//   byte_data   out  received byte, stable while byte_valid is high
//   frame_err   out  1-cycle pulse, the cycle after a stop bit sampled low
// -----------------------------------------------------------------------------
module zinde_uart_rx
   import zinde_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clkn,
   input  logic       rstn,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int             CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]  CNT_ZERO  = CW'(0);

   logic          rx_meta_r, rx_sync_r, rx_prev_r;
   rx_state_t     state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [2:0]    bit_r, bit_s;
   logic [7:0]    shift_r, shift_s;
   logic          valid_r, valid_s;
   logic          ferr_r, ferr_s;

   // Synchronizer, edge history and receiver state registers
   always_ff @(posedge clkn or negedge rstn) begin
      if (!rstn) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
         state_r   <= RX_IDLE;
         cnt_r     <= CNT_ZERO;
         bit_r     <= 3'd0;
         shift_r   <= 8'h00;
         valid_r   <= 1'b0;
         ferr_r    <= 1'b0;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         bit_r     <= bit_s;
         shift_r   <= shift_s;
         valid_r   <= valid_s;
         ferr_r    <= ferr_s;
      end
   end

   // Bit timing and next-state logic
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      bit_s   = bit_r;
      shift_s = shift_r;
      valid_s = 1'b0;
      ferr_s  = 1'b0;
      case (state_r)
         RX_IDLE: begin
            cnt_s = CNT_ZERO;
            if (rx_prev_r && !rx_sync_r) begin
               state_s = RX_START;
            end else begin
               state_s = RX_IDLE;
            end
         end
         RX_START: begin
            // A line that is high again at the start mid-point was a glitch
            if (cnt_r == HALF_LAST) begin
               cnt_s = CNT_ZERO;
               bit_s = 3'd0;
               if (!rx_sync_r) begin
                  state_s = RX_DATA;
               end else begin
                  state_s = RX_IDLE;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         RX_DATA: begin
            if (cnt_r == BIT_LAST) begin
               cnt_s   = CNT_ZERO;
               shift_s = {rx_sync_r, shift_r[7:1]};
               if (bit_r == 3'd7) begin
                  state_s = RX_STOP;
               end else begin
                  bit_s = bit_r + 3'd1;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         RX_STOP: begin
            if (cnt_r == BIT_LAST) begin
               cnt_s   = CNT_ZERO;
               state_s = RX_IDLE;
               if (rx_sync_r) begin
                  valid_s = 1'b1;
               end else begin
                  ferr_s = 1'b1;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = RX_IDLE;
         end
      endcase
   end

   assign byte_valid = valid_r;
   assign byte_data  = shift_r;
   assign frame_err  = ferr_r;

endmodule

// File: rtl/zinde_boot_loader.sv
// -----------------------------------------------------------------------------
// zinde_boot_loader
// Receives a framed program (A5, LEN, LEN bytes, SUM) over UART and writes it
// into the ZindeRV8 RAM through the load port, holding the CPU in reset until
// the checksum matches.
// Ports:
//   clkn      in   system clock, rising edge
//   rstn      in   asynchronous active-low reset
//   rx        in   UART serial input
//   sel_out   out  1 = loader owns the RAM
//   we_out    out  single-cycle RAM write strobe
//   adr_out   out  RAM write address
//   data_out  out  RAM write data
//   cpu_rstn  out  active-low CPU reset
//   busy      out  frame in progress
//   done      out  program loaded successfully
//   err       out  framing or checksum error seen
// -----------------------------------------------------------------------------
module zinde_boot_loader
   import zinde_pkg::*;
#(
   parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter logic [7:0] START_ADDR   = 8'h00
) (
   input  logic       clkn,
   input  logic       rstn,
   input  logic       rx,
   output logic       sel_out,
   output logic       we_out,
   output logic [7:0] adr_out,
   output logic [7:0] data_out,
   output logic       cpu_rstn,
   output logic       busy,
   output logic       done,
   output logic       err
);

   logic       byte_valid_s;
   logic [7:0] byte_data_s;
   logic       frame_err_s;

   ld_state_t  state_r, state_s;
   logic [8:0] cnt_r, cnt_s;
   logic [7:0] ptr_r, ptr_s;
   logic [7:0] sum_r, sum_s;
   logic [7:0] adr_r, adr_s;
   logic [7:0] data_r, data_s;
   logic       we_r, we_s;
   logic       sel_r, sel_s;
   logic       cpu_rstn_r, cpu_rstn_s;
   logic       busy_r, busy_s;
   logic       done_r, done_s;
   logic       err_r, err_s;

   zinde_uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clkn       (clkn),
      .rstn       (rstn),
      .rx         (rx),
      .byte_valid (byte_valid_s),
      .byte_data  (byte_data_s),
      .frame_err  (frame_err_s)
   );

   // Loader state, counters and registered RAM-port outputs
   always_ff @(posedge clkn or negedge rstn) begin
      if (!rstn) begin
         state_r    <= LD_IDLE;
         cnt_r      <= 9'd0;
         ptr_r      <= START_ADDR;
         sum_r      <= 8'h00;
         adr_r      <= START_ADDR;
         data_r     <= 8'h00;
         we_r       <= 1'b0;
         sel_r      <= 1'b1;
         cpu_rstn_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         ptr_r      <= ptr_s;
         sum_r      <= sum_s;
         adr_r      <= adr_s;
         data_r     <= data_s;
         we_r       <= we_s;
         sel_r      <= sel_s;
         cpu_rstn_r <= cpu_rstn_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         err_r      <= err_s;
      end
   end

   // Frame parser: next state and next output values
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      ptr_s      = ptr_r;
      sum_s      = sum_r;
      adr_s      = adr_r;
      data_s     = data_r;
      we_s       = 1'b0;
      sel_s      = sel_r;
      cpu_rstn_s = cpu_rstn_r;
      busy_s     = busy_r;
      done_s     = done_r;
      err_s      = err_r;
      case (state_r)
         LD_IDLE: begin
            if (frame_err_s) begin
               state_s = LD_ERR;
               err_s   = 1'b1;
               busy_s  = 1'b0;
            end else if (byte_valid_s && (byte_data_s == LOAD_HEADER)) begin
               state_s = LD_LEN;
               err_s   = 1'b0;
               busy_s  = 1'b1;
            end else begin
               state_s = LD_IDLE;
            end
         end
         LD_LEN: begin
            if (frame_err_s) begin
               state_s = LD_ERR;
               err_s   = 1'b1;
               busy_s  = 1'b0;
            end else if (byte_valid_s) begin
               // LEN of zero encodes a full 256-byte image
               cnt_s   = (byte_data_s == 8'h00) ? 9'd256 : {1'b0, byte_data_s};
               ptr_s   = START_ADDR;
               sum_s   = 8'h00;
               state_s = LD_DATA;
            end else begin
               state_s = LD_LEN;
            end
         end
         LD_DATA: begin
            if (frame_err_s) begin
               state_s = LD_ERR;
               err_s   = 1'b1;
               busy_s  = 1'b0;
            end else if (byte_valid_s) begin
               we_s   = 1'b1;
               adr_s  = ptr_r;
               data_s = byte_data_s;
               ptr_s  = ptr_r + 8'd1;
               sum_s  = sum_r + byte_data_s;
               cnt_s  = cnt_r - 9'd1;
               if (cnt_r == 9'd1) begin
                  state_s = LD_SUM;
               end else begin
                  state_s = LD_DATA;
               end
            end else begin
               state_s = LD_DATA;
            end
         end
         LD_SUM: begin
            if (frame_err_s) begin
               state_s = LD_ERR;
               err_s   = 1'b1;
               busy_s  = 1'b0;
            end else if (byte_valid_s) begin
               if (byte_data_s == sum_r) begin
                  state_s    = LD_RUN;
                  sel_s      = 1'b0;
                  cpu_rstn_s = 1'b1;
                  done_s     = 1'b1;
                  busy_s     = 1'b0;
               end else begin
                  state_s = LD_ERR;
                  err_s   = 1'b1;
                  busy_s  = 1'b0;
               end
            end else begin
               state_s = LD_SUM;
            end
         end
         LD_RUN: begin
            // Only rstn leaves RUN; serial traffic and framing errors are ignored
            state_s = LD_RUN;
         end
         LD_ERR: begin
            state_s = LD_IDLE;
         end
         default: begin
            state_s = LD_IDLE;
         end
      endcase
   end

   assign sel_out  = sel_r;
   assign we_out   = we_r;
   assign adr_out  = adr_r;
   assign data_out = data_r;
   assign cpu_rstn = cpu_rstn_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign err      = err_r;

endmodule

// File: tb/tb_zinde_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_zinde_boot_loader
// Self-checking bench: two loaders (START_ADDR 00 and FE) fed with 8N1 serial
// bytes. Expected RAM writes are queued as frames are driven and popped by a
// write monitor; status outputs are checked after each frame.
// -----------------------------------------------------------------------------
module tb_zinde_boot_loader;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rx0 = 1'b1;
   logic       rx1 = 1'b1;

   logic       sel_out0, we_out0, cpu_rstn0, busy0, done0, err0;
   logic [7:0] adr_out0, data_out0;
   logic       sel_out1, we_out1, cpu_rstn1, busy1, done1, err1;
   logic [7:0] adr_out1, data_out1;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] q0[$];
   logic [15:0] q1[$];
   logic [7:0]  ram0 [0:255];
   logic        mon_en = 1'b0;
   logic        we0_d = 1'b0, we1_d = 1'b0, done0_d = 1'b0, done1_d = 1'b0;

   typedef struct {
      logic [0:7][7:0] b;
      int              n;
      logic [0:3][7:0] w;
      int              nw;
      bit              rst;
      bit              exp_done;
      bit              exp_err;
   } vec_t;

   vec_t tab [5];

   always #5 clk = ~clk;

   zinde_boot_loader #(.CLKS_PER_BIT(CPB), .START_ADDR(8'h00)) dut0 (
      .clkn(clk), .rstn(rstn), .rx(rx0),
      .sel_out(sel_out0), .we_out(we_out0), .adr_out(adr_out0), .data_out(data_out0),
      .cpu_rstn(cpu_rstn0), .busy(busy0), .done(done0), .err(err0)
   );

   zinde_boot_loader #(.CLKS_PER_BIT(CPB), .START_ADDR(8'hFE)) dut1 (
      .clkn(clk), .rstn(rstn), .rx(rx1),
      .sel_out(sel_out1), .we_out(we_out1), .adr_out(adr_out1), .data_out(data_out1),
      .cpu_rstn(cpu_rstn1), .busy(busy1), .done(done1), .err(err1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Write monitor / scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      if (mon_en) begin
         if (we0_d) chk("we0_single_cycle", {31'd0, we_out0}, 32'd0);
         if (we1_d) chk("we1_single_cycle", {31'd0, we_out1}, 32'd0);
         if (we_out0) begin
            if (q0.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL write0_unexpected: got adr %0h data %0h, expected no write", adr_out0, data_out0);
            end else begin
               chk("write0", {16'd0, adr_out0, data_out0}, {16'd0, q0.pop_front()});
               ram0[adr_out0] = data_out0;
            end
         end
         if (we_out1) begin
            if (q1.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL write1_unexpected: got adr %0h data %0h, expected no write", adr_out1, data_out1);
            end else begin
               chk("write1", {16'd0, adr_out1, data_out1}, {16'd0, q1.pop_front()});
            end
         end
         if (done0 !== done0_d) chk("handover0", {30'd0, sel_out0, cpu_rstn0}, {30'd0, ~done0, done0});
         if (done1 !== done1_d) chk("handover1", {30'd0, sel_out1, cpu_rstn1}, {30'd0, ~done1, done1});
      end
      we0_d   = we_out0;
      we1_d   = we_out1;
      done0_d = done0;
      done1_d = done1;
   end

   task automatic set_rx(input int d, input logic v);
      if (d == 0) rx0 = v;
      else        rx1 = v;
   endtask

   task automatic send_byte(input int d, input logic [7:0] b, input logic stop);
      set_rx(d, 1'b0);
      repeat (CPB) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         set_rx(d, b[k]);
         repeat (CPB) @(negedge clk);
      end
      set_rx(d, stop);
      repeat (CPB) @(negedge clk);
      set_rx(d, 1'b1);
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic check_reset();
      chk("rst_sel0",  {31'd0, sel_out0},  32'd1);
      chk("rst_we0",   {31'd0, we_out0},   32'd0);
      chk("rst_adr0",  {24'd0, adr_out0},  32'h00);
      chk("rst_data0", {24'd0, data_out0}, 32'h00);
      chk("rst_cpu0",  {31'd0, cpu_rstn0}, 32'd0);
      chk("rst_busy0", {31'd0, busy0},     32'd0);
      chk("rst_done0", {31'd0, done0},     32'd0);
      chk("rst_err0",  {31'd0, err0},      32'd0);
      chk("rst_adr1",  {24'd0, adr_out1},  32'hFE);
      chk("rst_sel1",  {31'd0, sel_out1},  32'd1);
      chk("rst_cpu1",  {31'd0, cpu_rstn1}, 32'd0);
   endtask

   task automatic pulse_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check_reset();
      rstn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_status0(input string nm, input bit d, input bit e, input bit b);
      chk({nm, "_done"}, {31'd0, done0},     {31'd0, d});
      chk({nm, "_err"},  {31'd0, err0},      {31'd0, e});
      chk({nm, "_sel"},  {31'd0, sel_out0},  {31'd0, ~d});
      chk({nm, "_cpu"},  {31'd0, cpu_rstn0}, {31'd0, d});
      chk({nm, "_busy"}, {31'd0, busy0},     {31'd0, b});
   endtask

   initial begin
      tab[0] = '{{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66, 8'h00, 8'h00}, 6,
                 {8'h11, 8'h22, 8'h33, 8'h00}, 3, 1'b1, 1'b1, 1'b0};
      tab[1] = '{{8'hA5, 8'h02, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00}, 5,
                 {8'h01, 8'h02, 8'h00, 8'h00}, 2, 1'b1, 1'b0, 1'b1};
      tab[2] = '{{8'hA5, 8'h01, 8'h7E, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00}, 4,
                 {8'h7E, 8'h00, 8'h00, 8'h00}, 1, 1'b0, 1'b1, 1'b0};
      tab[3] = '{{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7E, 8'h00, 8'h00}, 6,
                 {8'h7E, 8'h00, 8'h00, 8'h00}, 1, 1'b1, 1'b1, 1'b0};
      tab[4] = '{{8'hA5, 8'h01, 8'h55, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00}, 4,
                 {8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b0, 1'b1, 1'b0};

      // Power-on reset
      repeat (3) @(negedge clk);
      check_reset();
      mon_en = 1'b1;
      rstn   = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven frames on the START_ADDR=00 loader
      for (int i = 0; i < 5; i++) begin
         if (tab[i].rst) pulse_reset();
         for (int k = 0; k < tab[i].nw; k++) q0.push_back({8'(k), tab[i].w[k]});
         for (int k = 0; k < tab[i].n; k++) send_byte(0, tab[i].b[k], 1'b1);
         check_status0($sformatf("vec%0d", i), tab[i].exp_done, tab[i].exp_err, 1'b0);
         if (tab[i].nw > 0) chk($sformatf("vec%0d_ram0", i), {24'd0, ram0[8'h00]}, {24'd0, tab[i].w[0]});
         chk($sformatf("vec%0d_pending", i), q0.size(), 32'd0);
      end

      // Framing error in DATA, then a header clears err and a frame completes
      pulse_reset();
      q0.push_back({8'h00, 8'h11});
      send_byte(0, 8'hA5, 1'b1);
      send_byte(0, 8'h02, 1'b1);
      send_byte(0, 8'h11, 1'b1);
      send_byte(0, 8'h22, 1'b0);
      check_status0("ferr", 1'b0, 1'b1, 1'b0);
      send_byte(0, 8'hA5, 1'b1);
      check_status0("ferr_hdr", 1'b0, 1'b0, 1'b1);
      q0.push_back({8'h00, 8'h5A});
      send_byte(0, 8'h01, 1'b1);
      send_byte(0, 8'h5A, 1'b1);
      send_byte(0, 8'h5A, 1'b1);
      check_status0("ferr_reload", 1'b1, 1'b0, 1'b0);

      // Short start-bit glitch in the middle of a frame
      pulse_reset();
      q0.push_back({8'h00, 8'h7E});
      send_byte(0, 8'hA5, 1'b1);
      send_byte(0, 8'h01, 1'b1);
      set_rx(0, 1'b0);
      @(negedge clk);
      set_rx(0, 1'b1);
      repeat (3 * CPB) @(negedge clk);
      check_status0("glitch", 1'b0, 1'b0, 1'b1);
      send_byte(0, 8'h7E, 1'b1);
      send_byte(0, 8'h7E, 1'b1);
      check_status0("glitch_done", 1'b1, 1'b0, 1'b0);

      // Reset mid-DATA aborts; a fresh frame loads
      pulse_reset();
      q0.push_back({8'h00, 8'h11});
      send_byte(0, 8'hA5, 1'b1);
      send_byte(0, 8'h03, 1'b1);
      send_byte(0, 8'h11, 1'b1);
      pulse_reset();
      q0.push_back({8'h00, 8'hC3});
      q0.push_back({8'h01, 8'h3C});
      send_byte(0, 8'hA5, 1'b1);
      send_byte(0, 8'h02, 1'b1);
      send_byte(0, 8'hC3, 1'b1);
      send_byte(0, 8'h3C, 1'b1);
      send_byte(0, 8'hFF, 1'b1);
      check_status0("rst_reload", 1'b1, 1'b0, 1'b0);
      chk("rst_reload_adr", {24'd0, adr_out0}, 32'h01);

      // Framing error while running is ignored
      send_byte(0, 8'h33, 1'b0);
      check_status0("run_ferr", 1'b1, 1'b0, 1'b0);

      // LEN=0 (256 bytes) with address wrap on the START_ADDR=FE loader
      for (int i = 0; i < 256; i++) q1.push_back({8'(8'hFE + i), 8'(i)});
      send_byte(1, 8'hA5, 1'b1);
      send_byte(1, 8'h00, 1'b1);
      for (int i = 0; i < 256; i++) send_byte(1, 8'(i), 1'b1);
      send_byte(1, 8'h80, 1'b1);
      chk("wrap_done", {31'd0, done1}, 32'd1);
      chk("wrap_err",  {31'd0, err1},  32'd0);
      chk("wrap_cpu",  {31'd0, cpu_rstn1}, 32'd1);
      chk("wrap_last_adr", {24'd0, adr_out1}, 32'hFD);
      chk("wrap_last_data", {24'd0, data_out1}, 32'hFF);

      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
